// File: rtl/banked_dual_port_ram.sv
// Dual-port RAM split into 2^TAG_W banks; each port has an independent write and read channel.
// Reads are read-first with 1-cycle latency; same-address simultaneous writes resolve to port b.
module banked_dual_port_ram #(
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req_a,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
  input  logic [DATA_WIDTH-1:0] s_write_data_a,
  input  logic                  s_read_req_a,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_a,
  output logic [DATA_WIDTH-1:0] s_read_data_a,
  input  logic                  s_write_req_b,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_b,
  input  logic [DATA_WIDTH-1:0] s_write_data_b,
  input  logic                  s_read_req_b,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_b,
  output logic [DATA_WIDTH-1:0] s_read_data_b
);

  localparam int unsigned ROW_W = ADDR_WIDTH - TAG_W;
  localparam int unsigned BANKS = 2 ** TAG_W;
  localparam int unsigned DEPTH = 2 ** ROW_W;

  logic [TAG_W-1:0] wr_bank_a, wr_bank_b, rd_bank_a, rd_bank_b;
  logic [ROW_W-1:0] wr_row_a, wr_row_b, rd_row_a, rd_row_b;
  logic [TAG_W-1:0] tag_a, tag_b;
  logic [BANKS-1:0][DATA_WIDTH-1:0] bank_q_a, bank_q_b;

  assign wr_bank_a = s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign wr_bank_b = s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign rd_bank_a = s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign rd_bank_b = s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign wr_row_a  = s_write_addr_a[ROW_W-1:0];
  assign wr_row_b  = s_write_addr_b[ROW_W-1:0];
  assign rd_row_a  = s_read_addr_a[ROW_W-1:0];
  assign rd_row_b  = s_read_addr_b[ROW_W-1:0];

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q_a, q_b;

    // Port b write is issued last so it overrides port a on an address collision.
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (s_write_req_a && (wr_bank_a == TAG_W'(g))) mem[wr_row_a] <= s_write_data_a;
        if (s_write_req_b && (wr_bank_b == TAG_W'(g))) mem[wr_row_b] <= s_write_data_b;
      end
    end

    // Per-bank read registers; sampling before the write lands gives read-first behaviour.
    always_ff @(posedge clk) begin
      if (reset) begin
        q_a <= '0;
        q_b <= '0;
      end else begin
        if (s_read_req_a && (rd_bank_a == TAG_W'(g))) q_a <= mem[rd_row_a];
        if (s_read_req_b && (rd_bank_b == TAG_W'(g))) q_b <= mem[rd_row_b];
      end
    end

    assign bank_q_a[g] = q_a;
    assign bank_q_b[g] = q_b;
  end

  // Registered bank tag steers the output mux; it only moves on a read so data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_a <= '0;
      tag_b <= '0;
    end else begin
      if (s_read_req_a) tag_a <= rd_bank_a;
      if (s_read_req_b) tag_b <= rd_bank_b;
    end
  end

  assign s_read_data_a = bank_q_a[tag_a];
  assign s_read_data_b = bank_q_b[tag_b];

endmodule

// File: tb/tb_banked_dual_port_ram.sv
// Table-driven directed bench for banked_dual_port_ram at TAG_W=2, ADDR_WIDTH=10, DATA_WIDTH=32.
module tb_banked_dual_port_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_write_req_a, s_read_req_a, s_write_req_b, s_read_req_b;
  logic [9:0]  s_write_addr_a, s_read_addr_a, s_write_addr_b, s_read_addr_b;
  logic [31:0] s_write_data_a, s_write_data_b, s_read_data_a, s_read_data_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  banked_dual_port_ram #(.TAG_W(2), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .s_write_req_a(s_write_req_a), .s_write_addr_a(s_write_addr_a), .s_write_data_a(s_write_data_a),
    .s_read_req_a(s_read_req_a), .s_read_addr_a(s_read_addr_a), .s_read_data_a(s_read_data_a),
    .s_write_req_b(s_write_req_b), .s_write_addr_b(s_write_addr_b), .s_write_data_b(s_write_data_b),
    .s_read_req_b(s_read_req_b), .s_read_addr_b(s_read_addr_b), .s_read_data_b(s_read_data_b)
  );

  typedef struct {
    logic        we_a; logic [9:0] wa_a; logic [31:0] wd_a; logic re_a; logic [9:0] ra_a;
    logic        we_b; logic [9:0] wa_b; logic [31:0] wd_b; logic re_b; logic [9:0] ra_b;
    logic        ck_a; logic [31:0] ex_a; logic ck_b; logic [31:0] ex_b;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  function automatic vec_t mk(
    input logic we_a, input logic [9:0] wa_a, input logic [31:0] wd_a, input logic re_a, input logic [9:0] ra_a,
    input logic we_b, input logic [9:0] wa_b, input logic [31:0] wd_b, input logic re_b, input logic [9:0] ra_b,
    input logic ck_a, input logic [31:0] ex_a, input logic ck_b, input logic [31:0] ex_b);
    vec_t v;
    v.we_a = we_a; v.wa_a = wa_a; v.wd_a = wd_a; v.re_a = re_a; v.ra_a = ra_a;
    v.we_b = we_b; v.wa_b = wa_b; v.wd_b = wd_b; v.re_b = re_b; v.ra_b = ra_b;
    v.ck_a = ck_a; v.ex_a = ex_a; v.ck_b = ck_b; v.ex_b = ex_b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    s_write_req_a = v.we_a; s_write_addr_a = v.wa_a; s_write_data_a = v.wd_a;
    s_read_req_a  = v.re_a; s_read_addr_a  = v.ra_a;
    s_write_req_b = v.we_b; s_write_addr_b = v.wa_b; s_write_data_b = v.wd_b;
    s_read_req_b  = v.re_b; s_read_addr_b  = v.ra_b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row is one clock; expectations are the outputs right after that row's edge.
    vec[0]  = mk(1, 10'h005, 32'h11111111, 0, 10'h000,  0, 10'h000, 32'h0, 0, 10'h000,  0, 32'h0, 0, 32'h0);
    vec[1]  = mk(0, 10'h000, 32'h0, 0, 10'h000,  0, 10'h000, 32'h0, 1, 10'h005,  0, 32'h0, 1, 32'h11111111);
    vec[2]  = mk(1, 10'h000, 32'hAAAA0000, 0, 10'h000,  1, 10'h3FF, 32'hBBBB03FF, 0, 10'h000,  0, 32'h0, 0, 32'h0);
    vec[3]  = mk(0, 10'h000, 32'h0, 1, 10'h000,  0, 10'h000, 32'h0, 1, 10'h3FF,  1, 32'hAAAA0000, 1, 32'hBBBB03FF);
    vec[4]  = mk(0, 10'h000, 32'h0, 1, 10'h3FF,  0, 10'h000, 32'h0, 1, 10'h000,  1, 32'hBBBB03FF, 1, 32'hAAAA0000);
    vec[5]  = mk(1, 10'h123, 32'hDEAD0001, 0, 10'h000,  1, 10'h123, 32'hBEEF0002, 0, 10'h000,  0, 32'h0, 0, 32'h0);
    vec[6]  = mk(0, 10'h000, 32'h0, 1, 10'h123,  0, 10'h000, 32'h0, 1, 10'h123,  1, 32'hBEEF0002, 1, 32'hBEEF0002);
    vec[7]  = mk(0, 10'h000, 32'h0, 0, 10'h000,  1, 10'h040, 32'h00000001, 0, 10'h000,  0, 32'h0, 0, 32'h0);
    vec[8]  = mk(1, 10'h040, 32'h00000002, 1, 10'h040,  0, 10'h000, 32'h0, 1, 10'h040,  1, 32'h1, 1, 32'h1);
    vec[9]  = mk(0, 10'h000, 32'h0, 1, 10'h040,  0, 10'h000, 32'h0, 1, 10'h040,  1, 32'h2, 1, 32'h2);
    vec[10] = mk(0, 10'h000, 32'h0, 1, 10'h005,  0, 10'h000, 32'h0, 0, 10'h000,  1, 32'h11111111, 1, 32'h2);
    vec[11] = mk(0, 10'h000, 32'h0, 0, 10'h000,  0, 10'h000, 32'h0, 0, 10'h000,  1, 32'h11111111, 1, 32'h2);
    vec[12] = mk(0, 10'h000, 32'h0, 0, 10'h000,  0, 10'h000, 32'h0, 0, 10'h000,  1, 32'h11111111, 1, 32'h2);
    vec[13] = mk(0, 10'h000, 32'h0, 0, 10'h000,  0, 10'h000, 32'h0, 0, 10'h000,  1, 32'h11111111, 1, 32'h2);
    vec[14] = mk(1, 10'h041, 32'h00000041, 0, 10'h000,  1, 10'h042, 32'h00000042, 0, 10'h000,  0, 32'h0, 0, 32'h0);
    vec[15] = mk(0, 10'h000, 32'h0, 1, 10'h041,  0, 10'h000, 32'h0, 1, 10'h042,  1, 32'h41, 1, 32'h42);

    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    check("reset_a", s_read_data_a, 32'h0);
    check("reset_b", s_read_data_b, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i]);
      step();
      if (vec[i].ck_a) check($sformatf("vec%0d_a", i), s_read_data_a, vec[i].ex_a);
      if (vec[i].ck_b) check($sformatf("vec%0d_b", i), s_read_data_b, vec[i].ex_b);
    end

    // Reset mid-traffic: reads and a write to 0x005 are presented but must be ignored.
    reset = 1'b1;
    drive(mk(1, 10'h005, 32'hFFFFFFFF, 1, 10'h041,  1, 10'h005, 32'hEEEEEEEE, 1, 10'h042,  0, 0, 0, 0));
    step();
    check("midreset_a", s_read_data_a, 32'h0);
    check("midreset_b", s_read_data_b, 32'h0);
    reset = 1'b0;
    drive(mk(0, 10'h000, 32'h0, 1, 10'h005,  0, 10'h000, 32'h0, 1, 10'h005,  0, 0, 0, 0));
    step();
    check("retain_a", s_read_data_a, 32'h11111111);
    check("retain_b", s_read_data_b, 32'h11111111);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    check("hold_after_reset_a", s_read_data_a, 32'h11111111);
    check("hold_after_reset_b", s_read_data_b, 32'h11111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/banked_dual_port_ram.md
Name: banked_dual_port_ram

Overview:
- Dual-port on-chip RAM split into 2^TAG_W equal banks.
- Each port (a, b) has one independent write channel and one independent read channel.
- Used per lane inside the output buffer: port a serves DRAM/memory-side traffic, port b serves compute-array-side traffic.
- Reads are synchronous with 1-cycle latency.

Parameters:
- TAG_W, default 2: log2 of the bank count; the upper TAG_W bits of every address select the bank. Must satisfy TAG_W < ADDR_WIDTH.
- ADDR_WIDTH, default 10: word address width; total depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, default 32: word width in bits.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- s_write_req_a, input, 1: port a write enable.
- s_write_addr_a, input, ADDR_WIDTH: port a write address.
- s_write_data_a, input, DATA_WIDTH: port a write data.
- s_read_req_a, input, 1: port a read enable.
- s_read_addr_a, input, ADDR_WIDTH: port a read address.
- s_read_data_a, output, DATA_WIDTH: port a read data, registered.
- s_write_req_b, input, 1: port b write enable.
- s_write_addr_b, input, ADDR_WIDTH: port b write address.
- s_write_data_b, input, DATA_WIDTH: port b write data.
- s_read_req_b, input, 1: port b read enable.
- s_read_addr_b, input, ADDR_WIDTH: port b read address.
- s_read_data_b, output, DATA_WIDTH: port b read data, registered.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Address split:
  - bank = addr[ADDR_WIDTH-1 -: TAG_W].
  - row = addr[ADDR_WIDTH-TAG_W-1:0].
  - Each bank holds 2^(ADDR_WIDTH-TAG_W) words.
- Write:
  - On a clk edge with s_write_req_x=1, the addressed bank/row is loaded with s_write_data_x.
  - There is no handshake; every request is accepted every cycle.
- Read:
  - On a clk edge with s_read_req_x=1, s_read_data_x is loaded with the word at s_read_addr_x.
  - The word is valid the cycle after the request (1-cycle latency).
  - Read data is produced by a per-port registered bank tag plus a bank output mux.
- No read request: s_read_data_x holds its last value.
- Throughput: back-to-back reads and writes on all four channels every cycle, including to different or identical banks.
- Simultaneous writes, same address: port b data wins. Different addresses (same or different bank): both writes are committed.
- Read and write to the same address in the same cycle, on either port combination: read-first; the read returns the old contents and the new value is visible from the next read.
- Reset:
  - s_read_data_a and s_read_data_b are cleared to 0 on the first edge with reset=1.
  - Read requests are ignored while reset=1.
  - Writes while reset=1 are ignored.
  - Memory array contents are not cleared; an unwritten word reads as X in simulation.
- Address wrap: addresses are exactly ADDR_WIDTH bits, so no out-of-range access is possible.

Test Plan:
- TAG_W=2, ADDR_WIDTH=10, DATA_WIDTH=32:
  - Port a writes 0x11111111 to address 0x005, then port b reads 0x005 -> s_read_data_b = 0x11111111 one cycle after the read request.
  - Same cycle: port a writes 0x000 = 0xAAAA0000 and port b writes 0x3FF = 0xBBBB03FF (different banks). Then both ports read both addresses -> each word returns correctly on both ports.
  - Same cycle: port a writes 0xDEAD0001 and port b writes 0xBEEF0002 to 0x123 -> a later read of 0x123 = 0xBEEF0002.
  - Address 0x040 holds 0x1, then in the same cycle port a writes 0x2 there and port b reads it -> read data = 0x1; next read = 0x2.
  - Read 0x005 (data 0x11111111), then deassert s_read_req_a for 3 cycles -> s_read_data_a stays 0x11111111.
  - Assert reset mid-traffic for 1 cycle -> both read data outputs = 0. After reset, read 0x005 -> 0x11111111 (contents retained).
